// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator with wrap-deferred tuning word updates,
// quarter-wave sine LUT plus triangle/saw/square, power-of-two attenuation about midscale.
module dds_wave_gen #(
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 9,
  parameter int OUT_W      = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  output logic               ftw_pending,
  input  logic               phase_clr,
  input  logic [1:0]         mode,
  input  logic [1:0]         amp_shift,
  output logic [OUT_W-1:0]   val,
  output logic               val_valid,
  output logic               wrap
);

  localparam int STAGES = 2;
  localparam int QN     = 1 << (LUT_ADDR_W - 2);
  localparam int AMP    = (1 << (OUT_W - 1)) - 1;
  localparam logic [OUT_W:0]        MID = (OUT_W + 1)'(1 << (OUT_W - 1));
  localparam logic [LUT_ADDR_W-2:0] QTR = (LUT_ADDR_W - 1)'(QN);

  // Quarter-wave table, entries 0..N/4 inclusive so the peak is stored exactly.
  logic [OUT_W-2:0] lut [0:QN];
  for (genvar j = 0; j <= QN; j++) begin : g_lut
    localparam int QV = int'(real'(AMP) * $sin(6.283185307179586 * real'(j) / real'(4 * QN)));
    assign lut[j] = (OUT_W - 1)'(QV);
  end

  // ---------------- stage 0: accumulator and tuning word ----------------
  logic [PHASE_W-1:0] phase, ftw_act, pend;
  logic [PHASE_W:0]   sum;
  logic               carry, apply;

  always_comb begin
    sum   = {1'b0, phase} + {1'b0, ftw_act};
    carry = en & ~phase_clr & sum[PHASE_W];
    // Safe moments to swap words: at the wrap, or whenever the phase is not advancing.
    apply = carry | ~en | phase_clr | (ftw_act == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      ftw_act     <= '0;
      pend        <= '0;
      ftw_pending <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      if (phase_clr)  phase <= '0;
      else if (en)    phase <= sum[PHASE_W-1:0];
      wrap <= carry;
      if (ftw_load) begin
        if (apply) begin
          ftw_act     <= ftw;
          ftw_pending <= 1'b0;
        end else begin
          pend        <= ftw;
          ftw_pending <= 1'b1;
        end
      end else if (apply && ftw_pending) begin
        ftw_act     <= pend;
        ftw_pending <= 1'b0;
      end
    end
  end

  // ---------------- stage 1: LUT read, phase bits pipelined ----------------
  logic [LUT_ADDR_W-1:0] k;
  logic [LUT_ADDR_W-2:0] i_ext, idx;
  logic [OUT_W-2:0]      lut_q;
  logic                  neg_r;
  logic [1:0]            mode_r, amp_r;
  logic [OUT_W:0]        top_r;

  always_comb begin
    k     = phase[PHASE_W-1 -: LUT_ADDR_W];
    i_ext = {1'b0, k[LUT_ADDR_W-3:0]};
    idx   = k[LUT_ADDR_W-2] ? (QTR - i_ext) : i_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q  <= '0;
      neg_r  <= 1'b0;
      mode_r <= '0;
      amp_r  <= '0;
      top_r  <= '0;
    end else begin
      lut_q  <= lut[idx];
      neg_r  <= k[LUT_ADDR_W-1];
      mode_r <= mode;
      amp_r  <= amp_shift;
      top_r  <= phase[PHASE_W-1 -: OUT_W+1];
    end
  end

  // ---------------- stage 2: waveform select and attenuation ----------------
  logic [OUT_W-1:0]        x;
  logic signed [OUT_W:0]   dev, att;
  logic [OUT_W:0]          res;
  logic [STAGES:1]         vld_pipe;

  always_comb begin
    unique case (mode_r)
      2'b00:   x = neg_r ? (MID[OUT_W-1:0] - {1'b0, lut_q}) : (MID[OUT_W-1:0] + {1'b0, lut_q});
      2'b01:   x = top_r[OUT_W] ? ~top_r[OUT_W-1:0] : top_r[OUT_W-1:0];
      2'b10:   x = top_r[OUT_W:1];
      default: x = top_r[OUT_W] ? '0 : '1;
    endcase
    dev = signed'({1'b0, x} - MID);
    att = dev >>> amp_r;
    res = MID + unsigned'(att);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val      <= MID[OUT_W-1:0];
      vld_pipe <= '0;
    end else begin
      val      <= res[OUT_W-1:0];
      vld_pipe <= {vld_pipe[STAGES-1:1], en};
    end
  end

  assign val_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: arithmetic reference model checked every cycle,
// a table of single-point waveform vectors and directed multi-cycle sequences.
module tb_dds_wave_gen;
  localparam int PW = 24, L = 9, OW = 9;
  localparam int N = 1 << L, M = 1 << (OW - 1), A = M - 1;
  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  logic rst_n, en, ftw_load, phase_clr, ftw_pending, val_valid, wrap;
  logic [PW-1:0] ftw;
  logic [1:0] mode, amp_shift;
  logic [OW-1:0] val;

  always #5 clk = ~clk;

  dds_wave_gen #(.PHASE_W(PW), .LUT_ADDR_W(L), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ftw(ftw), .ftw_load(ftw_load),
    .ftw_pending(ftw_pending), .phase_clr(phase_clr), .mode(mode),
    .amp_shift(amp_shift), .val(val), .val_valid(val_valid), .wrap(wrap)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;

  // reference model state
  longint m_phase, m_act, m_pend, s1_phase;
  bit m_pflag, m_vv, m_wrap, s1_en;
  int m_val, s1_mode, s1_amp;

  typedef struct { int mode; int amp; int k; int exp; } vec_t;
  vec_t tbl [17];

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Ideal waveform value for a phase, straight from the waveform definitions.
  function automatic int ref_wave(longint ph, int md, int amp);
    int kk, msb, x, t, s, d;
    kk  = int'(ph >> (PW - L));
    msb = int'(ph >> (PW - 1)) & 1;
    case (md)
      0: x = M + int'(real'(A) * $sin(2.0 * PI * real'(kk) / real'(N)));
      1: begin
        t = int'(ph >> (PW - 1 - OW)) % (1 << OW);
        x = msb ? ((1 << OW) - 1 - t) : t;
      end
      2: x = int'(ph >> (PW - OW));
      default: x = msb ? 0 : (1 << OW) - 1;
    endcase
    s = x - M;
    d = 1 << amp;
    s = (s >= 0) ? s / d : -((-s + d - 1) / d);  // floor division
    return M + s;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_act = 0; m_pend = 0; m_pflag = 0;
    m_val = M; m_vv = 0; m_wrap = 0;
    s1_phase = 0; s1_mode = 0; s1_amp = 0; s1_en = 0;
  endfunction

  function automatic void model_edge();
    longint sum;
    bit carry, apply;
    m_val = ref_wave(s1_phase, s1_mode, s1_amp);
    m_vv  = s1_en;
    s1_phase = m_phase; s1_mode = int'(mode); s1_amp = int'(amp_shift); s1_en = en;
    sum   = m_phase + m_act;
    carry = en && !phase_clr && (sum >= (longint'(1) << PW));
    apply = carry || !en || phase_clr || (m_act == 0);
    if (phase_clr) m_phase = 0;
    else if (en)   m_phase = sum % (longint'(1) << PW);
    m_wrap = carry;
    if (ftw_load) begin
      if (apply) begin m_act = longint'(ftw); m_pflag = 0; end
      else begin m_pend = longint'(ftw); m_pflag = 1; end
    end else if (apply && m_pflag) begin
      m_act = m_pend; m_pflag = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("val", int'(val), m_val);
    chk("val_valid", int'(val_valid), int'(m_vv));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("ftw_pending", int'(ftw_pending), int'(m_pflag));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic load_clr(int w);
    ftw = PW'(w); ftw_load = 1'b1; phase_clr = 1'b1; en = 1'b0;
    step();
    ftw_load = 1'b0; phase_clr = 1'b0;
  endtask

  task automatic wait_wrap(int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      step();
      cycles++;
      if (wrap) break;
    end
    if (cycles >= budget && !wrap) chk("wrap_timeout", cycles, -1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_val"}, int'(val), M);
    chk({tag, "_val_valid"}, int'(val_valid), 0);
    chk({tag, "_wrap"}, int'(wrap), 0);
    chk({tag, "_ftw_pending"}, int'(ftw_pending), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c, e;
    tbl[0]  = '{0, 0, 0, 256};   tbl[1]  = '{0, 0, 1, 259};
    tbl[2]  = '{0, 0, 128, 511}; tbl[3]  = '{0, 0, 256, 256};
    tbl[4]  = '{0, 0, 384, 1};   tbl[5]  = '{0, 1, 128, 383};
    tbl[6]  = '{0, 1, 384, 128}; tbl[7]  = '{3, 1, 0, 383};
    tbl[8]  = '{3, 1, 300, 128}; tbl[9]  = '{3, 3, 10, 287};
    tbl[10] = '{3, 3, 400, 224}; tbl[11] = '{2, 0, 100, 100};
    tbl[12] = '{2, 2, 511, 319}; tbl[13] = '{1, 0, 255, 510};
    tbl[14] = '{1, 0, 256, 511}; tbl[15] = '{1, 0, 384, 255};
    tbl[16] = '{1, 1, 0, 128};

    // reset held with random inputs
    rst_n = 1'b0;
    repeat (5) begin
      en = 1'($urandom); ftw_load = 1'($urandom); phase_clr = 1'($urandom);
      ftw = PW'($urandom); mode = 2'($urandom); amp_shift = 2'($urandom);
      @(posedge clk); #1;
      chk_reset_vals("rst_hold");
    end
    en = 1'b0; ftw_load = 1'b0; phase_clr = 1'b0; mode = 2'd0;
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      step();
      chk("idle_val", int'(val), M);
    end

    // sine sweep, one LUT step per cycle
    mode = 2'd0; amp_shift = 2'd0;
    load_clr(32'h008000);
    en = 1'b1;
    wait_wrap(600, c); chk("wrap_period_1", c, 512);
    wait_wrap(600, c); chk("wrap_period_2", c, 512);

    // deferred frequency change, second load overwrites the first
    run(100);
    ftw = PW'(32'h010000); ftw_load = 1'b1; step(); ftw_load = 1'b0;
    chk("pending_set", int'(ftw_pending), 1);
    run(100);
    ftw = PW'(32'h020000); ftw_load = 1'b1; step(); ftw_load = 1'b0;
    chk("pending_still", int'(ftw_pending), 1);
    wait_wrap(600, c);
    chk("pending_clear_at_wrap", int'(ftw_pending), 0);
    wait_wrap(600, c); chk("wrap_period_last_word", c, 128);

    // synchronous clear during running sine
    load_clr(32'h008000);
    en = 1'b1;
    run(200);
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    chk("clr_no_wrap", int'(wrap), 0);
    step(); step();
    chk("clr_val_k0", int'(val), 256);
    step();
    chk("clr_val_k1", int'(val), 259);
    run(508);
    phase_clr = 1'b1; step(); phase_clr = 1'b0;
    chk("clr_at_carry_no_wrap", int'(wrap), 0);

    // zero tuning word with en=1: constant but valid
    en = 1'b0; ftw = '0; ftw_load = 1'b1; step(); ftw_load = 1'b0;
    en = 1'b1;
    run(3);
    e = m_val;
    repeat (5) begin
      step();
      chk("ftw0_const", int'(val), e);
      chk("ftw0_valid", int'(val_valid), 1);
    end

    // table of single-point waveform vectors
    for (int i = 0; i < 17; i++) begin
      mode = 2'(tbl[i].mode); amp_shift = 2'(tbl[i].amp);
      load_clr(32'h008000);
      en = 1'b1; run(tbl[i].k);
      en = 1'b0; run(3);
      chk($sformatf("tbl%0d", i), int'(val), tbl[i].exp);
    end

    // randomized operation
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      ftw_load = ($urandom_range(0, 30) == 0);
      ftw = $urandom_range(0, 1) ? PW'($urandom) : PW'($urandom_range(0, 1 << 17));
      phase_clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) begin
        mode = 2'($urandom); amp_shift = 2'($urandom);
      end
      step();
    end
    ftw_load = 1'b0; phase_clr = 1'b0;

    // asynchronous reset mid-sweep with a pending word
    mode = 2'd0; amp_shift = 2'd0;
    load_clr(32'h008000);
    en = 1'b1; run(50);
    ftw = PW'(32'h010000); ftw_load = 1'b1; step(); ftw_load = 1'b0;
    chk("pre_reset_pending", int'(ftw_pending), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 rst_n = 1'b1;
    model_reset();
    run(4);
    chk("post_reset_val", int'(val), M);
    chk("post_reset_pending", int'(ftw_pending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
- Parametrised direct-digital-synthesis waveform generator. It is the successor to the fixed 9-bit sine lookup driven by an external counter.
- It owns its phase accumulator and takes a runtime frequency tuning word. Frequency changes are glitch-free and take effect at phase wrap.
- It generates sine (quarter-wave LUT), triangle, sawtooth and square waves, with power-of-two amplitude attenuation about midscale.
- The output is unsigned offset-binary and feeds the DAC/PWM output stage.

Parameters:
- PHASE_W, 24: phase accumulator and tuning word width.
- LUT_ADDR_W, 9: full-wave sample index width, N = 2^LUT_ADDR_W. The quarter LUT holds N/4+1 entries. Must be ≥ 4.
- OUT_W, 9: output sample width, with M = 2^(OUT_W-1) and A = M-1. Must satisfy OUT_W ≤ PHASE_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  advance the accumulator by the active tuning word this cycle.
- ftw  in  PHASE_W  tuning word to load.
- ftw_load  in  1  1-cycle request to load ftw.
- ftw_pending  out  1  a loaded tuning word is waiting for an apply event.
- phase_clr  in  1  synchronous accumulator clear.
- mode  in  2  waveform select: 00 sine, 01 triangle, 10 saw, 11 square.
- amp_shift  in  2  attenuation, arithmetic right-shift of (x-M).
- val  out  OUT_W  output sample.
- val_valid  out  1  val corresponds to an advanced phase.
- wrap  out  1  1-cycle pulse when the phase register has just wrapped.

Behaviour:
- Reset (async, while rst_n=0): phase=0, ftw_act=0, pend=0, ftw_pending=0, val=M (256 at defaults), val_valid=0, wrap=0. All pipeline registers cleared to midscale/0.
- Accumulator, stage 0:
  - if phase_clr: phase<=0.
  - else if en: phase<=phase+ftw_act, modulo 2^PHASE_W.
  - else: phase holds.
  - carry = en & ~phase_clr & carry-out of the sum. wrap<=carry, so wrap rises in the same cycle as the wrapped phase value.
- Apply event: carry, or en=0, or phase_clr, or ftw_act==0.
- Tuning word update (ftw_act):
  - ftw_load & apply: ftw_act<=ftw; pend cleared.
  - ftw_load & ~apply: pend<=ftw, overwriting any older pending word; ftw_pending<=1.
  - ~ftw_load & apply & ftw_pending: ftw_act<=pend; ftw_pending<=0.
  - A word applied at a carry is used from the next increment. The increment that produced the carry uses the old word.
- Stage 1, registered:
  - k = phase[PHASE_W-1 -: LUT_ADDR_W]; q = k[MSB:MSB-1]; i = k mod N/4.
  - LUT index = (q odd) ? N/4-i : i. The registered LUT read Q[j] = round(A*sin(2πj/N)).
  - The sign flag (q≥2), the mode and the folded phase bits are pipelined alongside.
- Stage 2, registered, producing val:
  - sine: M+Q for q<2, M-Q otherwise. Range 1..2M-1.
  - saw: phase[PHASE_W-1 -: OUT_W].
  - triangle: let t = phase[PHASE_W-2 -: OUT_W]. Output t when the phase MSB is 0, ~t otherwise.
  - square: 2^OUT_W-1 when the phase MSB is 0, 0 otherwise.
  - Then s = x-M as signed OUT_W+1 bits; val = M + (s >>> amp_shift), truncated to OUT_W.
- Latency: val reflects the phase register value from 2 cycles earlier. val_valid is en delayed 2 cycles. mode and amp_shift are sampled with the phase, so they also have 2-cycle latency.
- Boundaries:
  - ftw=0 with en=1: phase holds, and val is constant but valid.
  - ftw ≥ 2^(PHASE_W-1): aliasing is permitted; no special handling.
  - phase_clr together with en: clear wins, and no wrap pulse occurs.
  - phase_clr does not flush the pipeline; 2 in-flight samples still emerge.
  - rst_n asserted mid-operation: immediate return to the reset values, pending word discarded.

Test Plan (defaults PHASE_W=24, LUT_ADDR_W=9, OUT_W=9):
- Reset: hold rst_n=0 with random inputs → val=256, val_valid=0, wrap=0, ftw_pending=0. Release, keep en=0 → outputs unchanged.
- Sine sweep: load ftw=0x008000 (k steps by 1 per cycle), mode=00, en=1 → val=256, 259, … with 511 at k=128, 256 at k=256 and 1 at k=384. wrap pulses every 512 cycles. All 512 samples must match the golden model.
- Square with attenuation: mode=11, amp_shift=1, ftw=0x008000 → val alternates 383 and 128, 256 samples each. With amp_shift=3 → 287 and 224.
- Deferred frequency change:
  - With ftw_act=0x008000 at k≈100, pulse ftw_load with ftw=0x010000 → ftw_pending=1 until the cycle after the carry.
  - After the wrap, k steps by 2 and the wrap period is 256 cycles.
  - A second load before the wrap overwrites the pending word, and only the last word is applied.
- phase_clr at k=200, en=1 → the phase register is 0 next cycle. Sine val reaches 256 two cycles later and then follows the k=0,1,… sequence. No wrap pulse.
- Mid-run reset: pulse rst_n low for less than one clock period between edges during a sine sweep with a pending word → outputs go to reset values asynchronously. After release, ftw_act=0 and no pending word.
